// File: rtl/pito_pkg.sv
// Shared APB widths, loader state encoding and request record for the pito APB loader.
package pito_pkg;

  localparam int unsigned APB_ADDR_WIDTH = 32;
  localparam int unsigned APB_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    LDR_IDLE   = 2'd0,
    LDR_SETUP  = 2'd1,
    LDR_ACCESS = 2'd2
  } ldr_state_e;

  typedef struct packed {
    logic                      write;
    logic [APB_ADDR_WIDTH-1:0] addr;
    logic [APB_DATA_WIDTH-1:0] wdata;
  } apb_req_t;

endpackage

// File: rtl/pito_apb_req_fifo.sv
// Request buffer for the APB loader: power-of-two depth, show-ahead head, async active-high reset.
module pito_apb_req_fifo #(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pito_apb_req_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pito_apb_loader.sv
// Queues read/write requests and replays them as APB master transfers, one per two cycles.
// Optional ACCESS watchdog enabled by defining PITO_APB_LOADER_TIMEOUT_EN.
module pito_apb_loader
  import pito_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic                    pready,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pslverr
);

  localparam int unsigned REQ_W = 1 + ADDR_WIDTH + DATA_WIDTH;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
    $error("pito_apb_loader: TIMEOUT_CYCLES must be at least 1");
  end

  ldr_state_e            state;
  logic [REQ_W-1:0]      fifo_dout;
  logic                  fifo_full, fifo_empty;
  logic                  push, pop, timeout, xfer_done;
  logic                  head_write;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_wdata;

  assign req_ready = !fifo_full && !rst;
  assign push      = req_valid && req_ready;
  assign {head_write, head_addr, head_wdata} = fifo_dout;

  pito_apb_req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({req_write, req_addr, req_wdata}),
    .pop   (pop),
    .rdata (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef PITO_APB_LOADER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  // Counts stalled ACCESS cycles; restarts on every fresh transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     tmo_cnt <= '0;
    else if (state != LDR_ACCESS) tmo_cnt <= '0;
    else if (!pready)            tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign timeout = (state == LDR_ACCESS) && !pready && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  assign xfer_done = (state == LDR_ACCESS) && (pready || timeout);
  // Next head is launched straight out of ACCESS so back-to-back transfers skip IDLE.
  assign pop  = !fifo_empty && ((state == LDR_IDLE) || xfer_done);
  assign busy = (state != LDR_IDLE) || !fifo_empty || rsp_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LDR_IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      pstrb     <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        LDR_SETUP: begin
          penable <= 1'b1;
          state   <= LDR_ACCESS;
        end
        LDR_ACCESS: begin
          if (xfer_done) begin
            rsp_valid <= 1'b1;
            rsp_err   <= pslverr || timeout;
            rsp_rdata <= (pwrite || timeout) ? '0 : prdata;
            psel      <= 1'b0;
            penable   <= 1'b0;
            state     <= LDR_IDLE;
          end
        end
        default: state <= LDR_IDLE;
      endcase
      if (pop) begin
        paddr   <= head_addr;
        pwrite  <= head_write;
        pwdata  <= head_wdata;
        pstrb   <= {(DATA_WIDTH/8){head_write}};
        psel    <= 1'b1;
        penable <= 1'b0;
        state   <= LDR_SETUP;
      end
    end
  end

endmodule

// File: tb/tb_pito_apb_loader.sv
// Directed bench for pito_apb_loader; honours PITO_APB_LOADER_TIMEOUT_EN with TIMEOUT_CYCLES=8.
module tb_pito_apb_loader;
  import pito_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic [31:0] paddr, pwdata;
  logic        psel, penable, pwrite;
  logic [3:0]  pstrb;
  logic        pready = 1'b0, pslverr = 1'b0;
  logic [31:0] prdata = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pito_apb_loader #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input apb_req_t r);
    req_valid = 1'b1;
    req_write = r.write;
    req_addr  = r.addr;
    req_wdata = r.wdata;
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", req_ready); end
    checks++; if ({psel, penable, pwrite, rsp_valid, rsp_err, busy} !== 6'b0) begin errors++;
      $display("FAIL rst_ctrl got %b exp 000000", {psel, penable, pwrite, rsp_valid, rsp_err, busy}); end
    checks++; if ({paddr, pwdata, pstrb, rsp_rdata} !== '0) begin errors++;
      $display("FAIL rst_data paddr %h pwdata %h pstrb %h rdata %h exp 0", paddr, pwdata, pstrb, rsp_rdata); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rel_ready got %b exp 1", req_ready); end
    tick();
  endtask

  task automatic test_write();
    pready = 1'b1; prdata = 32'hFFFF_FFFF;
    drive('{write: 1'b1, addr: 32'h0000_0010, wdata: 32'hDEAD_BEEF});
    tick();  // cycle N
    req_valid = 1'b0;
    checks++; if (psel !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL wr_n psel %b busy %b exp 0 1", psel, busy); end
    tick();  // N+1
    checks++; if (psel !== 1'b1 || penable !== 1'b0) begin errors++; $display("FAIL wr_setup psel %b pen %b exp 1 0", psel, penable); end
    checks++; if (paddr !== 32'h10 || pwrite !== 1'b1 || pwdata !== 32'hDEAD_BEEF || pstrb !== 4'hF) begin errors++;
      $display("FAIL wr_setup_bus paddr %h pwrite %b pwdata %h pstrb %h", paddr, pwrite, pwdata, pstrb); end
    tick();  // N+2
    checks++; if (psel !== 1'b1 || penable !== 1'b1 || paddr !== 32'h10 || pwdata !== 32'hDEAD_BEEF) begin errors++;
      $display("FAIL wr_access psel %b pen %b paddr %h pwdata %h", psel, penable, paddr, pwdata); end
    tick();  // N+3
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin errors++;
      $display("FAIL wr_rsp valid %b err %b rdata %h exp 1 0 0", rsp_valid, rsp_err, rsp_rdata); end
    checks++; if (psel !== 1'b0) begin errors++; $display("FAIL wr_rsp_psel got %b exp 0", psel); end
    tick();
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL wr_after valid %b busy %b exp 0 0", rsp_valid, busy); end
  endtask

  task automatic test_wait_read();
    int pen = 0;
    pready = 1'b0; prdata = 32'h1234_5678;
    drive('{write: 1'b0, addr: 32'h0000_0020, wdata: 32'hFFFF_FFFF});
    tick();
    req_valid = 1'b0;
    tick();  // SETUP
    checks++; if (pstrb !== 4'h0 || pwrite !== 1'b0 || paddr !== 32'h20) begin errors++;
      $display("FAIL rd_setup pstrb %h pwrite %b paddr %h exp 0 0 20", pstrb, pwrite, paddr); end
    for (int k = 0; k < 4; k++) begin
      tick();
      if (penable === 1'b1) pen++;
      if (k == 3) pready = 1'b1;
    end
    checks++; if (pen != 4) begin errors++; $display("FAIL rd_penable_cycles got %0d exp 4", pen); end
    tick();
    pready = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_5678 || rsp_err !== 1'b0) begin errors++;
      $display("FAIL rd_rsp valid %b rdata %h err %b exp 1 12345678 0", rsp_valid, rsp_rdata, rsp_err); end
    tick();
  endtask

  task automatic test_back_to_back();
    int acc = 0, done = 0, rsps = 0, last = 0, drop = -1;
    pready = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      pready = (cyc >= 20);
      if (acc < 6) drive('{write: 1'b1, addr: 32'h100 + 32'(acc * 4), wdata: 32'hA0 + 32'(acc)});
      else req_valid = 1'b0;
      if (psel && penable && pready) begin
        checks++; if (paddr !== 32'h100 + 32'(done * 4) || pwdata !== 32'hA0 + 32'(done)) begin errors++;
          $display("FAIL b2b_order idx %0d paddr %h pwdata %h", done, paddr, pwdata); end
        checks++; if ((done == 0 && cyc != 20) || (done > 0 && cyc - last != 2)) begin errors++;
          $display("FAIL b2b_gap idx %0d cyc %0d last %0d exp first 20 then +2", done, cyc, last); end
        last = cyc;
        done++;
      end
      if (rsp_valid === 1'b1) begin
        rsps++;
        checks++; if (rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin errors++;
          $display("FAIL b2b_rsp err %b rdata %h exp 0 0", rsp_err, rsp_rdata); end
      end
      if (req_valid && !req_ready && drop < 0) drop = acc;
      if (req_valid && req_ready) acc++;
      tick();
    end
    req_valid = 1'b0; pready = 1'b0;
    checks++; if (drop != 5) begin errors++; $display("FAIL b2b_ready_drop got %0d accepted exp 5", drop); end
    checks++; if (done != 6 || rsps != 6) begin errors++; $display("FAIL b2b_count xfers %0d rsps %0d exp 6 6", done, rsps); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle busy %b exp 0", busy); end
  endtask

  task automatic test_slverr();
    pready = 1'b1; pslverr = 1'b1; prdata = 32'h0BAD_0BAD;
    drive('{write: 1'b0, addr: 32'h0000_0030, wdata: 32'h0});
    tick();
    req_valid = 1'b0;
    tick(); tick(); tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || busy !== 1'b1) begin errors++;
      $display("FAIL err_rsp valid %b err %b busy %b exp 1 1 1", rsp_valid, rsp_err, busy); end
    pslverr = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL err_busy busy %b valid %b exp 0 0", busy, rsp_valid); end
    pready = 1'b0;
  endtask

  task automatic test_reset_abort();
    int bad = 0;
    pready = 1'b0;
    drive('{write: 1'b0, addr: 32'h200, wdata: 32'h0});
    tick();
    drive('{write: 1'b0, addr: 32'h204, wdata: 32'h0});
    tick();
    drive('{write: 1'b0, addr: 32'h208, wdata: 32'h0});
    tick();
    req_valid = 1'b0;
    checks++; if (penable !== 1'b1) begin errors++; $display("FAIL abort_access1 pen %b exp 1", penable); end
    tick();
    rst = 1'b1;
    #1;
    checks++; if (psel !== 1'b0 || penable !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b0) begin errors++;
      $display("FAIL abort_rst psel %b pen %b busy %b ready %b exp 0 0 0 0", psel, penable, busy, req_ready); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b exp 1", req_ready); end
    pready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (rsp_valid !== 1'b0 || psel !== 1'b0 || busy !== 1'b0) bad++;
    end
    pready = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL abort_quiet got %0d active cycles exp 0", bad); end
  endtask

  task automatic test_stall();
    int pen = 0;
    bit got = 1'b0;
    pready = 1'b0;
    drive('{write: 1'b1, addr: 32'h40, wdata: 32'h5555_AAAA});
    tick();
    req_valid = 1'b0;
    tick();  // SETUP
`ifdef PITO_APB_LOADER_TIMEOUT_EN
    for (int k = 0; k < 30 && !got; k++) begin
      tick();
      if (rsp_valid === 1'b1) begin
        got = 1'b1;
        checks++; if (pen != 8 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || psel !== 1'b0 || penable !== 1'b0) begin errors++;
          $display("FAIL tmo_rsp access %0d err %b rdata %h psel %b pen %b exp 8 1 0 0 0", pen, rsp_err, rsp_rdata, psel, penable); end
      end else if (penable === 1'b1) pen++;
    end
    checks++; if (!got) begin errors++; $display("FAIL tmo_none got no rsp_valid exp 1"); end
`else
    for (int k = 0; k < 20; k++) begin
      tick();
      if (penable === 1'b1 && rsp_valid === 1'b0) pen++;
    end
    checks++; if (pen != 20) begin errors++; $display("FAIL stall_hold got %0d access cycles exp 20", pen); end
    pready = 1'b1;
    tick();
    pready = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin errors++;
      $display("FAIL stall_rsp valid %b err %b exp 1 0", rsp_valid, rsp_err); end
`endif
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_idle busy %b exp 0", busy); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_wait_read();
    test_back_to_back();
    test_slverr();
    test_reset_abort();
    test_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
